// File: rtl/avmm_resp_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
package avmm_resp_pkg;

  localparam int ERR_COUNT_W = 16;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_t;

endpackage

// File: rtl/avmm_resp_ram.sv
// Simple dual-port RAM: byte-enabled write port, one-cycle registered read port.
module avmm_resp_ram #(
  parameter int DATA_W = 256,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes and registered read; read-during-write returns old data.
  // NOTE: the storage array and read register have no reset; contents survive reset and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wbe[b]) mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst responder: byte-enabled on-chip memory with fixed read
// latency, burst reads/writes, SLVERR on out-of-range reads and an error counter.
module avmm_burst_responder
  import avmm_resp_pkg::*;
#(
  parameter int DATA_W         = 256,
  parameter int ADDR_W         = 64,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int BURST_W        = 8,
  parameter int READ_LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      avs_address,
  input  logic [BURST_W-1:0]     avs_burstcount,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [DATA_W-1:0]      avs_writedata,
  input  logic [DATA_W/8-1:0]    avs_byteenable,
  output logic                   avs_waitrequest,
  output logic [DATA_W-1:0]      avs_readdata,
  output logic                   avs_readdatavalid,
  output logic [1:0]             avs_response,
  output logic [ERR_COUNT_W-1:0] err_count
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  // One spare bit so a burst running past the top of the address space
  // cannot wrap back into the valid range.
  localparam int IDX_W = ADDR_W - OFF_W + 1;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;    // word index of the next beat
  logic [BURST_W-1:0]     left_q, left_d;  // beats remaining in the burst
  logic [ERR_COUNT_W-1:0] err_q, err_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;   // stage 0 aligns with RAM output
  logic [READ_LATENCY-1:0] slv_q, slv_d;   // beat was out of range

  logic [IDX_W-1:0]   cmd_idx;
  logic [BURST_W-1:0] cmd_len;
  logic               cmd_zero;
  logic               cmd_misaligned;
  logic [IDX_W-1:0]   beat_idx;
  logic               beat_wr;
  logic               beat_rd;
  logic               beat_oob;
  logic [2:0]         err_inc;
  logic [ERR_COUNT_W:0] err_sum;
  logic [DATA_W-1:0]  ram_rdata;
  logic [DATA_W-1:0]  rd_data_out;

  assign cmd_idx        = {1'b0, avs_address[ADDR_W-1:OFF_W]};
  assign cmd_zero       = (avs_burstcount == '0);
  assign cmd_len        = cmd_zero ? BURST_W'(1) : avs_burstcount;
  assign cmd_misaligned = |avs_address[OFF_W-1:0];

  // Reads hold off new commands while beats are being issued.
  assign avs_waitrequest = reset | (state_q == RD_BURST);

  // Command decode, beat sequencing and error-event collection.
  // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    left_d   = left_q;
    beat_idx = idx_q;
    beat_wr  = 1'b0;
    beat_rd  = 1'b0;
    err_inc  = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (avs_write) begin
            // Write wins over a simultaneous read; the read costs an error.
            beat_wr  = 1'b1;
            beat_idx = cmd_idx;
            err_inc  = 3'(avs_read) + 3'(cmd_misaligned) + 3'(cmd_zero);
            if (cmd_len > BURST_W'(1)) begin
              state_d = WR_BURST;
              idx_d   = cmd_idx + IDX_W'(1);
              left_d  = cmd_len - BURST_W'(1);
            end
          end else if (avs_read) begin
            beat_rd  = 1'b1;
            beat_idx = cmd_idx;
            err_inc  = 3'(cmd_misaligned) + 3'(cmd_zero);
            if (cmd_len > BURST_W'(1)) begin
              state_d = RD_BURST;
              idx_d   = cmd_idx + IDX_W'(1);
              left_d  = cmd_len - BURST_W'(1);
            end
          end
        end
        WR_BURST: begin
          err_inc = 3'(avs_read);
          if (avs_write) begin
            beat_wr = 1'b1;
            idx_d   = idx_q + IDX_W'(1);
            left_d  = left_q - BURST_W'(1);
            if (left_q == BURST_W'(1)) state_d = IDLE;
          end
        end
        RD_BURST: begin
          beat_rd = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          left_d  = left_q - BURST_W'(1);
          if (left_q == BURST_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    beat_oob = |beat_idx[IDX_W-1:MEM_DEPTH_LOG2];
    if ((beat_wr || beat_rd) && beat_oob) err_inc = err_inc + 3'd1;
  end

  // Saturating error counter update.
  always_comb begin
    err_sum = {1'b0, err_q} + (ERR_COUNT_W + 1)'(err_inc);
    err_d   = err_sum[ERR_COUNT_W] ? '1 : err_sum[ERR_COUNT_W-1:0];
  end

  // Read-beat valid/error shift register running alongside the RAM read.
  always_comb begin
    vld_d    = '0;
    slv_d    = '0;
    vld_d[0] = beat_rd;
    slv_d[0] = beat_rd & beat_oob;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      slv_d[i] = slv_q[i-1];
    end
  end

  // Control state; reset returns to IDLE and flushes in-flight read beats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      left_q  <= '0;
      err_q   <= '0;
      vld_q   <= '0;
      slv_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      slv_q   <= slv_d;
    end
  end

  avmm_resp_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (beat_wr & ~beat_oob),
    .waddr (beat_idx[MEM_DEPTH_LOG2-1:0]),
    .wdata (avs_writedata),
    .wbe   (avs_byteenable),
    .raddr (beat_idx[MEM_DEPTH_LOG2-1:0]),
    .rdata (ram_rdata)
  );

  // Remaining READ_LATENCY-1 data stages after the RAM's own output register.
  if (READ_LATENCY == 1) begin : g_no_pipe
    assign rd_data_out = ram_rdata;
  end else begin : g_pipe
    logic [DATA_W-1:0] dat_q [READ_LATENCY-1];
    logic [DATA_W-1:0] dat_d [READ_LATENCY-1];

    // Shift read data forward one stage per cycle.
    always_comb begin
      dat_d[0] = ram_rdata;
      for (int i = 1; i < READ_LATENCY - 1; i++) dat_d[i] = dat_q[i-1];
    end

    // Data stages carry no reset; valid qualifies them.
    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign rd_data_out = dat_q[READ_LATENCY-2];
  end

  assign avs_readdatavalid = vld_q[READ_LATENCY-1] & ~reset;
  assign avs_response      = (avs_readdatavalid && slv_q[READ_LATENCY-1]) ? SLVERR : OKAY;
  assign avs_readdata      = (avs_readdatavalid && !slv_q[READ_LATENCY-1]) ? rd_data_out : '0;
  assign err_count         = reset ? '0 : err_q;

endmodule
